ps2_host_ctrl: RTL

//  Avalon-MM controller for the PS/2 keyboard port: buffers received scan codes in a FIFO and sequences

---
 rtl/ps2_host_ctrl.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_host_ctrl
//   Avalon-MM controller for a PS/2 keyboard port. Received frames from an
//   external ps2_receive decoder are validated and queued in an RX FIFO.
//   Host-to-device commands are sent by inhibiting the clock, issuing a
//   request-to-send, shifting out data/parity/stop on the device's falling
//   clock edges and checking the device ACK. One level IRQ covers both
//   "RX data available" and "TX complete".
//
// Ports
//   clock, clock_sreset       system clock, synchronous active-high reset
//   ps2_clk_in, ps2_dat_in    asynchronous PS/2 pad inputs
//   ps2_clk_oe, ps2_dat_oe    open-drain pull-down enables (1 = drive low)
//   rx_valid, rx_frame        frame strobe and {stop,parity,data,start}
//   s_address .. s_waitrequest  Avalon-MM slave (word addresses 0..3)
//   irq                       registered level interrupt
//
// Register map
//   0x0 CTRL   b0 irq_en RW, b1 rx_nempty RO, b2 tx_busy RO, b3 tx_done W1C,
//              b4 tx_err W1C, b5 rx_ovf W1C, b6 rx_perr W1C
//   0x1 RXDATA {23'b0, valid, data[7:0]}, pops when valid
//   0x2 TXDATA write starts a transmit when idle
//   0x3 LEVEL  FIFO occupancy
// ---------------------------------------------------------------------------
module ps2_host_ctrl #(
    parameter int SYSTEM_CLOCK = 50000000,
    parameter int FIFO_DEPTH   = 16,
    parameter int INHIBIT_US   = 120,
    parameter int TIMEOUT_MS   = 15
) (
    input  logic        clock,
    input  logic        clock_sreset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe,
    input  logic        rx_valid,
    input  logic [10:0] rx_frame,
    input  logic [3:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic        irq
);

    // 64-bit intermediates: INHIBIT_US * SYSTEM_CLOCK overflows 32 bits.
    localparam longint INHIBIT_L = longint'(INHIBIT_US) * longint'(SYSTEM_CLOCK) / 64'd1000000;
    localparam longint TIMEOUT_L = longint'(TIMEOUT_MS) * longint'(SYSTEM_CLOCK) / 64'd1000;
    localparam int     INHIBIT_CYCLES = int'(INHIBIT_L);
    localparam int     TIMEOUT_CYCLES = int'(TIMEOUT_L);
    localparam int     WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int     AW   = $clog2(FIFO_DEPTH);

    localparam logic [WD_W-1:0] INH_LAST = WD_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0] TO_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]     DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_RELEASE
    } state_t;

    // ---------------- pad synchronisers ----------------
    logic r_clk_meta, r_clk_sync, r_clk_prev, r_dat_meta, r_dat_sync;
    logic w_clk_fall;

    // Reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_clk_fall = r_clk_prev & ~r_clk_sync;

    // ---------------- state and flag registers ----------------
    state_t          r_state;
    logic [WD_W-1:0] r_wdog;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_tx_byte;
    logic            r_tx_par;
    logic            r_clk_oe, r_dat_oe;
    logic            r_irq_en, r_tx_done, r_tx_err, r_rx_ovf, r_rx_perr;
    logic            r_rd_phase, r_irq;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_level;

    // ---------------- bus decode ----------------
    logic w_wr_ctrl, w_wr_tx, w_rd_first, w_empty, w_full, w_tx_busy;
    logic w_unused;

    assign w_wr_ctrl     = s_write & (s_address == 4'h0);
    assign w_wr_tx       = s_write & (s_address == 4'h2);
    assign w_rd_first    = s_read & ~r_rd_phase;
    assign s_waitrequest = w_rd_first;
    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == DEPTH_L);
    assign w_tx_busy     = (r_state != S_IDLE);
    assign w_unused      = ^s_writedata[31:8];

    // ---------------- RX path ----------------
    logic w_frame_ok, w_rx_take, w_push, w_pop, w_set_ovf, w_set_perr;

    // start=0, stop=1, odd parity over data+parity.
    assign w_frame_ok = ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1]);
    assign w_rx_take  = rx_valid & ~w_tx_busy;
    assign w_push     = w_rx_take & w_frame_ok & ~w_full;
    assign w_set_ovf  = w_rx_take & w_frame_ok & w_full;
    assign w_set_perr = w_rx_take & ~w_frame_ok;
    assign w_pop      = w_rd_first & (s_address == 4'h1) & ~w_empty;

    // NOTE: storage arrays carry no reset; validity is tracked by the
    // pointers and level, which are reset.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= rx_frame[8:1];
    end

    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ---------------- TX FSM: next-state logic ----------------
    state_t          w_state_nxt;
    logic [WD_W-1:0] w_wdog_nxt;
    logic [3:0]      w_bit_cnt_nxt;
    logic            w_clk_oe_nxt, w_dat_oe_nxt, w_load, w_set_done, w_set_err;

    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_wdog_nxt    = r_wdog + WD_W'(1);
        w_bit_cnt_nxt = r_bit_cnt;
        w_clk_oe_nxt  = r_clk_oe;
        w_dat_oe_nxt  = r_dat_oe;
        w_load        = 1'b0;
        w_set_done    = 1'b0;
        w_set_err     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_wdog_nxt   = '0;
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (w_wr_tx) begin
                    w_load        = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_clk_oe_nxt  = 1'b1;
                    w_state_nxt   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                // Watchdog starts at 0 on entry, so it doubles as inhibit timer.
                if (r_wdog == INH_LAST) begin
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b1;
                    w_state_nxt  = S_REQ;
                end
            end
            S_REQ: w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt < 4'd8) begin
                        w_dat_oe_nxt = ~r_tx_byte[r_bit_cnt[2:0]];
                    end else if (r_bit_cnt == 4'd8) begin
                        w_dat_oe_nxt = ~r_tx_par;
                    end else begin
                        w_dat_oe_nxt = 1'b0;  // stop bit: release the line
                        w_state_nxt  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_clk_fall) begin
                    w_set_err   = r_dat_sync;  // device holds data low to ACK
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (r_clk_sync) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Watchdog overrides any in-progress step.
        if (r_state != S_IDLE && r_wdog == TO_LAST) begin
            w_state_nxt  = S_IDLE;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_set_done   = 1'b1;
            w_set_err    = 1'b1;
        end
    end

    // ---------------- TX FSM, flags, bus and irq registers ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; combinational blocks above use blocking ones.
    always_ff @(posedge clock) begin
        if (clock_sreset) begin
            r_state    <= S_IDLE;
            r_wdog     <= '0;
            r_bit_cnt  <= '0;
            r_tx_byte  <= '0;
            r_tx_par   <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rd_phase <= 1'b0;
            r_irq      <= 1'b0;
            s_readdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wdog    <= w_wdog_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            if (w_load) begin
                r_tx_byte <= s_writedata[7:0];
                r_tx_par  <= ~^s_writedata[7:0];
            end

            if (w_wr_ctrl) r_irq_en <= s_writedata[0];
            // Hardware set wins over a same-cycle write-1-to-clear.
            r_tx_done <= w_set_done | (r_tx_done & ~(w_wr_ctrl & s_writedata[3]));
            r_tx_err  <= w_set_err  | (r_tx_err  & ~(w_wr_ctrl & s_writedata[4]));
            r_rx_ovf  <= w_set_ovf  | (r_rx_ovf  & ~(w_wr_ctrl & s_writedata[5]));
            r_rx_perr <= w_set_perr | (r_rx_perr & ~(w_wr_ctrl & s_writedata[6]));

            // Each read spends one wait cycle; data is captured in that cycle.
            r_rd_phase <= w_rd_first;
            if (w_rd_first) begin
                case (s_address)
                    4'h0: s_readdata <= {25'd0, r_rx_perr, r_rx_ovf, r_tx_err, r_tx_done,
                                         w_tx_busy, ~w_empty, r_irq_en};
                    4'h1: s_readdata <= w_empty ? 32'd0 : {23'd0, 1'b1, r_mem[r_rd_ptr]};
                    4'h3: s_readdata <= 32'(r_level);
                    default: s_readdata <= 32'd0;
                endcase
            end

            r_irq <= r_irq_en & (~w_empty | r_tx_done);
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign irq        = r_irq;

endmodule
